stack_seq: RTL

Stack sequencer for the SRP16 core: the memory-facing end of the stack-pointer interface. It accepts one push or pop request at a time from the control unit and owns the 16-bit stack pointer. It issues the matching req/ack transaction on the data-memory port and returns popped data. Bounds faults are detected before any memory traffic is issued.

---
 rtl/srp16_stack_pkg.sv | 17 +
 rtl/stack_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/srp16_stack_pkg.sv
// Shared types and constants for the SRP16 stack sequencer.
package srp16_stack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } stack_state_t;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_OVF  = 2'b01;
    localparam logic [1:0] FLT_UDF  = 2'b10;

    localparam logic [15:0] DEF_STACK_BASE  = 16'h0000;
    localparam logic [15:0] DEF_STACK_LIMIT = 16'hF000;

endpackage

// File: rtl/stack_seq.sv
// Stack sequencer: owns the full-descending SP and runs one req/ack memory transaction per push/pop.
// Bounds faults are caught at acceptance, so a faulting request never reaches the memory port.
module stack_seq
    import srp16_stack_pkg::*;
#(
    parameter logic [15:0] STACK_BASE  = DEF_STACK_BASE,
    parameter logic [15:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_push,
    input  logic [15:0] op_data,
    output logic        op_ready,
    output logic        res_valid,
    output logic [15:0] res_data,
    input  logic        sp_wr,
    input  logic [15:0] sp_din,
    output logic [15:0] sp_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        fault,
    output logic [1:0]  fault_code
);

    stack_state_t r_state;
    stack_state_t w_state_nxt;

    logic [15:0] r_sp;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_res_data;
    logic        r_res_valid;
    logic        r_fault;
    logic [1:0]  r_fault_code;

    logic w_idle;
    logic w_accept;
    logic w_ovf;
    logic w_udf;
    logic w_start;

    assign w_idle   = (r_state == IDLE);
    assign op_ready = w_idle && !sp_wr;
    assign w_accept = op_valid && op_ready;
    assign w_ovf    = w_accept &&  op_push && (r_sp == STACK_LIMIT);
    assign w_udf    = w_accept && !op_push && (r_sp == STACK_BASE);
    assign w_start  = w_accept && !w_ovf && !w_udf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = op_push ? PUSH : POP;
                end
            end
            PUSH, POP: begin
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // mem_req comes straight from the state register so reset removes it asynchronously.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (r_state)
            PUSH: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            POP: begin
                mem_req = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
                mem_we  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp         <= STACK_BASE;
            r_mem_addr   <= 16'h0000;
            r_mem_wdata  <= 16'h0000;
            r_res_data   <= 16'h0000;
            r_res_valid  <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FLT_NONE;
        end else begin
            r_res_valid  <= (r_state == POP) && mem_ack;
            r_fault      <= w_ovf || w_udf;
            r_fault_code <= w_ovf ? FLT_OVF : (w_udf ? FLT_UDF : FLT_NONE);

            if (w_idle && sp_wr) begin
                r_sp <= sp_din;
            end else if ((r_state == PUSH) && mem_ack) begin
                r_sp <= r_sp - 16'd1;
            end else if ((r_state == POP) && mem_ack) begin
                r_sp <= r_sp + 16'd1;
            end

            if (w_start) begin
                r_mem_addr  <= op_push ? (r_sp - 16'd1) : r_sp;
                r_mem_wdata <= op_data;
            end

            if ((r_state == POP) && mem_ack) begin
                r_res_data <= mem_rdata;
            end
        end
    end

    assign sp_out     = r_sp;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign res_data   = r_res_data;
    assign res_valid  = r_res_valid;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
